// File: rtl/ps2_keyboard_reader_if.sv
// CPU-side keyboard bus: the memory-mapping logic pulses key_read and
// samples the keyboard status/data word; frame_err flags receive errors.
interface ps2_keyboard_reader_if;
    logic        key_read;
    logic [31:0] keyboard;
    logic        frame_err;

    // Memory-mapping logic / CPU side
    modport master (
        output key_read,
        input  keyboard,
        input  frame_err
    );

    // Keyboard reader side
    modport slave (
        input  key_read,
        output keyboard,
        output frame_err
    );
endinterface

// File: rtl/ps2_keyboard_reader.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, decodes 11-bit
// frames, drops break sequences, tags E0-extended codes and buffers make
// codes in a small FIFO whose head is presented as a 32-bit status word.
module ps2_keyboard_reader #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_keyboard_reader_if.slave        bus
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          PTR_W   = PW + 1;
    localparam int          TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  CODE_EXT = 8'hE0;
    localparam logic [7:0]  CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and falling-edge detect
    // ------------------------------------------------------------------
    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic ps2_data_s1_q, ps2_data_s2_q;
    logic ps2_fall;

    // Two-flop synchronizers plus one history flop for edge detection; idle lines are high.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= ps2_clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_data_s1_q  <= ps2_data;
            ps2_data_s2_q  <= ps2_data_s1_q;
        end
    end

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

    // ------------------------------------------------------------------
    // Frame receiver and prefix decoder
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            stop_q;
    logic [TO_W-1:0] timeout_q;
    logic            frame_err_q;
    logic            ext_flag_q;
    logic            brk_flag_q;
    logic            frame_ok;
    logic            is_prefix;

    // Odd parity over data+parity, and the stop bit must be high.
    assign frame_ok  = (^{shift_q, parity_q}) & stop_q;
    assign is_prefix = (shift_q == CODE_EXT) || (shift_q == CODE_BRK);

    // Frame FSM: collects start/data/parity/stop, validates, tracks E0/F0 prefixes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            stop_q      <= 1'b0;
            timeout_q   <= '0;
            frame_err_q <= 1'b0;
            ext_flag_q  <= 1'b0;
            brk_flag_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= '0;
                    // Only a low data bit on a falling edge starts a frame.
                    if (ps2_fall && !ps2_data_s2_q) begin
                        state_q   <= ST_RECV;
                        bit_cnt_q <= '0;
                    end
                end

                ST_RECV: begin
                    if (ps2_fall) begin
                        timeout_q <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            shift_q <= {ps2_data_s2_q, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            parity_q <= ps2_data_s2_q;
                        end else begin
                            stop_q  <= ps2_data_s2_q;
                            state_q <= ST_CHECK;
                        end
                    end else if (timeout_q == TO_LAST) begin
                        // Keyboard stalled mid-frame: drop the partial frame and any prefix.
                        state_q     <= ST_IDLE;
                        timeout_q   <= '0;
                        frame_err_q <= 1'b1;
                        ext_flag_q  <= 1'b0;
                        brk_flag_q  <= 1'b0;
                    end else begin
                        timeout_q <= timeout_q + TO_W'(1);
                    end
                end

                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    if (!frame_ok) begin
                        frame_err_q <= 1'b1;
                    end else if (shift_q == CODE_EXT) begin
                        ext_flag_q <= 1'b1;
                    end else if (shift_q == CODE_BRK) begin
                        brk_flag_q <= 1'b1;
                    end else begin
                        // Either pushed (make) or discarded (break); both end the sequence.
                        ext_flag_q <= 1'b0;
                        brk_flag_q <= 1'b0;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Make-code FIFO
    // ------------------------------------------------------------------
    logic             push_req;
    logic [8:0]       push_data;
    logic             fifo_empty, fifo_full;
    logic             pop, push_acc;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [8:0]       mem_q [FIFO_DEPTH];

    assign push_req  = (state_q == ST_CHECK) && frame_ok && !is_prefix && !brk_flag_q;
    assign push_data = {ext_flag_q, shift_q};

    // Pointer/overflow next-state; a simultaneous pop frees the slot a full-FIFO push needs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        pop        = bus.key_read && !fifo_empty;
        push_acc   = push_req && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        overflow_d = overflow_q;
        if (bus.key_read && overflow_q) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_acc) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the reset pointers make every entry unreachable until rewritten.
        if (push_acc) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

    // Status/data word presented to the CPU.
    always_comb begin
        bus.keyboard     = '0;
        bus.keyboard[31] = !fifo_empty;
        bus.keyboard[30] = overflow_q;
        if (!fifo_empty) begin
            bus.keyboard[8:0] = mem_q[rd_ptr_q[PW-1:0]];
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_reader.sv
// Scoreboard bench for ps2_keyboard_reader: a byte-stream reference model
// queues expected make codes; a monitor drains and compares the FIFO head.
module tb_ps2_keyboard_reader;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic key_read_stim = 1'b0;
    logic key_read_mon = 1'b0;
    bit   drain_en = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard_reader_if bus ();
    assign bus.key_read = key_read_stim | key_read_mon;

    ps2_keyboard_reader #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int exp_err = 0;

    // Reference model: expected FIFO contents, prefix state, sticky overflow.
    logic [8:0] exp_q[$];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    bit m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        w[30] = m_ovf;
        if (exp_q.size() != 0) begin
            w[31]  = 1'b1;
            w[8:0] = exp_q[0];
        end
        return w;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                else exp_q.push_back({m_ext, b});
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_pop();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_ovf = 1'b0;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
    endfunction

    // Count frame_err cycles; a one-cycle pulse counts exactly once.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_seen++;
    end

    // Monitor: whenever the DUT presents a code, compare it against the scoreboard and pop it.
    always @(negedge clk) begin
        if (key_read_mon) begin
            key_read_mon = 1'b0;
        end else if (drain_en && reset_n && bus.keyboard[31] === 1'b1) begin
            check("drain head", bus.keyboard, model_word());
            model_pop();
            key_read_mon = 1'b1;
        end
    end

    // Send nbits of an 11-bit frame; optionally pulse key_read in the push cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit pop_sync);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (3) @(negedge clk);
                if (pop_sync) begin
                    check("sync pop head", bus.keyboard, model_word());
                    model_pop();
                    key_read_stim = 1'b1;
                end
                model_byte(b, !bad_par);
                @(negedge clk);
                key_read_stim = 1'b0;
                repeat (HALF - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic cpu_read(input string name, input logic [31:0] exp_before);
        @(negedge clk);
        check(name, bus.keyboard, exp_before);
        model_pop();
        key_read_stim = 1'b1;
        @(negedge clk);
        key_read_stim = 1'b0;
        check("after read", bus.keyboard, model_word());
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.keyboard[31] !== 1'b0); i++)
            @(negedge clk);
        check("drained word", bus.keyboard, 32'h0);
        check("model drained", exp_q.size(), 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rv;
        logic [7:0]  b;
        logic [31:0] seq_exp [4];

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset keyboard", bus.keyboard, 32'h0);
        check("reset frame_err", {31'b0, bus.frame_err}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code, then reads
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("make 1C", bus.keyboard, 32'h8000001C);
        check("no frame_err", err_seen, exp_err);
        cpu_read("read 1C", 32'h8000001C);
        cpu_read("read empty", 32'h0);

        // Break sequence is dropped; extended code is tagged
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("break dropped", bus.keyboard, 32'h0);
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'h75, 1'b0, 11, 1'b0);
        check("extended 75", bus.keyboard, 32'h80000175);
        cpu_read("read E0 75", 32'h80000175);

        // Parity error, then timeout, then recovery
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check("parity err count", err_seen, exp_err);
        check("parity no entry", bus.keyboard, 32'h0);
        send_frame(8'h3B, 1'b0, 5, 1'b0);
        repeat (TIMEOUT + 50) @(negedge clk);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("timeout err count", err_seen, exp_err);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        check("after timeout 29", bus.keyboard, 32'h80000029);
        cpu_read("read 29", 32'h80000029);

        // Overflow: five pushes into a depth-4 FIFO
        send_frame(8'h15, 1'b0, 11, 1'b0);
        send_frame(8'h1D, 1'b0, 11, 1'b0);
        send_frame(8'h24, 1'b0, 11, 1'b0);
        send_frame(8'h2D, 1'b0, 11, 1'b0);
        send_frame(8'h2C, 1'b0, 11, 1'b0);
        check("overflow head", bus.keyboard, 32'hC0000015);
        seq_exp[0] = 32'hC0000015;
        seq_exp[1] = 32'h8000001D;
        seq_exp[2] = 32'h80000024;
        seq_exp[3] = 32'h8000002D;
        for (int i = 0; i < 4; i++) cpu_read("overflow read", seq_exp[i]);
        check("overflow empty", bus.keyboard, 32'h0);

        // Reset mid-frame discards state and the partial frame
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        send_frame(8'h5A, 1'b0, 7, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid-frame reset word", bus.keyboard, 32'h0);
        check("mid-frame reset err", {31'b0, bus.frame_err}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (HALF * 4) @(negedge clk);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        check("post reset 1C", bus.keyboard, 32'h8000001C);
        cpu_read("read post reset", 32'h8000001C);

        // Full FIFO with push and pop in the same cycle
        send_frame(8'h15, 1'b0, 11, 1'b0);
        send_frame(8'h1D, 1'b0, 11, 1'b0);
        send_frame(8'h24, 1'b0, 11, 1'b0);
        send_frame(8'h2D, 1'b0, 11, 1'b0);
        check("full head", bus.keyboard, 32'h80000015);
        send_frame(8'h2C, 1'b0, 11, 1'b1);
        check("sync no overflow", bus.keyboard, 32'h8000001D);
        drain_en = 1'b1;
        wait_drain();

        // Randomized byte stream drained by the monitor
        for (int n = 0; n < 40; n++) begin
            rv = $urandom_range(0, 9);
            if (rv < 2) b = 8'hE0;
            else if (rv == 2) b = 8'hF0;
            else begin
                rv = $urandom;
                b = rv[7:0];
            end
            send_frame(b, ($urandom_range(0, 7) == 0), 11, 1'b0);
        end
        wait_drain();
        check("random err count", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
